// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with registered handshake, done pulse and sticky overrun.
// Define UART_TX_PARITY_EN for an 8E1 frame with an even parity bit after bit 7.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ctrl,
  input  logic [7:0] data_send,
  output logic       transmit_ready,
  output logic       tx_serial,
  output logic       tx_done,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      shreg;
  logic [2:0]      idx;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            par_bit;
`endif

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      shreg          <= '0;
      idx            <= '0;
      transmit_ready <= 1'b1;
      tx_serial      <= 1'b1;
      tx_done        <= 1'b0;
      overrun        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit        <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (tx_ctrl && !transmit_ready)
        overrun <= 1'b1;
      if (state != IDLE)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (tx_ctrl) begin
            shreg          <= data_send;
            idx            <= '0;
            cnt            <= '0;
            state          <= START;
            tx_serial      <= 1'b0;
            transmit_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit        <= ^data_send;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            tx_serial <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= par_bit;
`else
              state     <= STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              tx_serial <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            tx_serial <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state          <= IDLE;
            transmit_ready <= 1'b1;
            tx_done        <= 1'b1;
            tx_serial      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
